// File: rtl/div_ctrl_if.sv
// Request/response bundle between the EXE stage (master) and the iterative divider (slave).
interface div_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             div_req;
    logic [3:0]       div_op;
    logic [WIDTH-1:0] div_src1;
    logic [WIDTH-1:0] div_src2;
    logic             div_flush;
    logic             div_ack;
    logic             div_busy;
    logic             div_done;
    logic [WIDTH-1:0] div_result;

    modport master (
        output div_req, div_op, div_src1, div_src2, div_flush, div_ack,
        input  div_busy, div_done, div_result
    );

    modport slave (
        input  div_req, div_op, div_src1, div_src2, div_flush, div_ack,
        output div_busy, div_done, div_result
    );
endinterface

// File: rtl/div_ctrl.sv
// Radix-2 restoring divider with IDLE/CALC/DONE sequencer for div.w, mod.w, div.wu, mod.wu.
// Operands are made non-negative at accept; signs are re-applied when the result is registered.
module div_ctrl #(
    parameter int WIDTH = 32
) (
    input logic       clk,
    input logic       reset,
    div_ctrl_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       op_q, op_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;

    // Illegal (zero or multi-hot) encodings fall back to div.wu: unsigned, quotient.
    function automatic logic op_legal(input logic [3:0] op);
        return (op != 4'd0) && ((op & (op - 4'd1)) == 4'd0);
    endfunction

    function automatic logic op_is_mod(input logic [3:0] op);
        return op_legal(op) && (op[1] || op[3]);
    endfunction

    logic             acc_signed, acc_mod;
    logic             a_msb, b_msb;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic             div_by_zero, sgn_ovf;

    always_comb begin
        acc_signed  = op_legal(bus.div_op) && (bus.div_op[0] || bus.div_op[1]);
        acc_mod     = op_is_mod(bus.div_op);
        a_msb       = bus.div_src1[WIDTH-1];
        b_msb       = bus.div_src2[WIDTH-1];
        abs_a       = (acc_signed && a_msb) ? -bus.div_src1 : bus.div_src1;
        abs_b       = (acc_signed && b_msb) ? -bus.div_src2 : bus.div_src2;
        div_by_zero = (bus.div_src2 == '0);
        sgn_ovf     = acc_signed && (bus.div_src1 == MIN_NEG) && (bus.div_src2 == '1);
    end

    // One restoring step: the trial difference is WIDTH+1 bits so its MSB is the borrow.
    logic [WIDTH:0]   r_shift, trial;
    logic [WIDTH-1:0] step_rem, step_quo, fin_rem, fin_quo;

    always_comb begin
        r_shift  = {rem_q, quo_q[WIDTH-1]};
        trial    = r_shift - {1'b0, dvs_q};
        step_rem = trial[WIDTH] ? r_shift[WIDTH-1:0] : trial[WIDTH-1:0];
        step_quo = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
        fin_quo  = neg_quo_q ? -step_quo : step_quo;
        fin_rem  = neg_rem_q ? -step_rem : step_rem;
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        result_d  = result_q;
        op_d      = op_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;

        case (state_q)
            IDLE: begin
                if (bus.div_req && !bus.div_flush) begin
                    op_d      = bus.div_op;
                    neg_quo_d = acc_signed && (a_msb ^ b_msb);
                    neg_rem_d = acc_signed && a_msb;
                    dvs_d     = abs_b;
                    count_d   = '0;
                    if (div_by_zero) begin
                        quo_d    = '1;
                        rem_d    = bus.div_src1;
                        result_d = acc_mod ? bus.div_src1 : '1;
                        state_d  = DONE;
                    end else if (sgn_ovf) begin
                        quo_d    = MIN_NEG;
                        rem_d    = '0;
                        result_d = acc_mod ? '0 : MIN_NEG;
                        state_d  = DONE;
                    end else begin
                        quo_d   = abs_a;
                        rem_d   = '0;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                rem_d   = step_rem;
                quo_d   = step_quo;
                count_d = count_q + CW'(1);
                if (count_q == CW'(WIDTH - 1)) begin
                    result_d = op_is_mod(op_q) ? fin_rem : fin_quo;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (bus.div_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (bus.div_flush) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            result_q  <= '0;
            op_q      <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            result_q  <= result_d;
            op_q      <= op_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    assign bus.div_busy   = (state_q != IDLE);
    assign bus.div_done   = (state_q == DONE);
    assign bus.div_result = result_q;
endmodule

// File: tb/tb_div_ctrl.sv
// Directed plus randomized bench for div_ctrl against an arithmetic reference of the
// LoongArch divide semantics and the fixed accept-to-done latency.
module tb_div_ctrl;
    localparam int W = 32;
    localparam logic [3:0] OP_DIV_W  = 4'b0001;
    localparam logic [3:0] OP_MOD_W  = 4'b0010;
    localparam logic [3:0] OP_DIV_WU = 4'b0100;
    localparam logic [3:0] OP_MOD_WU = 4'b1000;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    div_ctrl_if #(.WIDTH(W)) bus ();
    div_ctrl #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit is_special(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bit sgn;
        sgn = (op == OP_DIV_W) || (op == OP_MOD_W);
        return (b == 32'd0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bit sgn, md;
        int sa, sb;
        logic [31:0] q, r;
        sgn = (op == OP_DIV_W) || (op == OP_MOD_W);
        md  = (op == OP_MOD_W) || (op == OP_MOD_WU);
        sa  = $signed(a);
        sb  = $signed(b);
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; r = a;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000; r = 32'd0;
        end else if (sgn) begin
            q = sa / sb; r = sa % sb;
        end else begin
            q = a / b; r = a % b;
        end
        return md ? r : q;
    endfunction

    // hold < 0: ack already high at request; otherwise ack held low for `hold` cycles of DONE.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int hold);
        int          lat;
        int          exp_lat;
        logic [31:0] exp;
        exp     = ref_result(op, a, b);
        exp_lat = is_special(op, a, b) ? 1 : W + 1;
        @(negedge clk);
        bus.div_req  = 1'b1;
        bus.div_op   = op;
        bus.div_src1 = a;
        bus.div_src2 = b;
        bus.div_ack  = (hold < 0);
        @(posedge clk); #1;
        lat = 1;
        check({tag, " busy"}, 32'(bus.div_busy), 32'd1);
        while (!bus.div_done && lat < 80) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " result"}, bus.div_result, exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, " hold done"}, 32'(bus.div_done), 32'd1);
            check({tag, " hold result"}, bus.div_result, exp);
        end
        @(negedge clk);
        bus.div_req = 1'b0;
        bus.div_ack = 1'b1;
        @(posedge clk); #1;
        check({tag, " idle busy"}, 32'(bus.div_busy), 32'd0);
        check({tag, " idle done"}, 32'(bus.div_done), 32'd0);
        @(negedge clk);
        bus.div_ack = 1'b0;
        $display("op %b a=%h b=%h -> result=%h latency=%0d", op, a, b, exp, lat);
    endtask

    initial begin
        int          seen;
        logic [3:0]  rop;
        logic [31:0] ra, rb;

        reset         = 1'b1;
        bus.div_req   = 1'b0;
        bus.div_op    = 4'd0;
        bus.div_src1  = 32'd0;
        bus.div_src2  = 32'd0;
        bus.div_flush = 1'b0;
        bus.div_ack   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 32'(bus.div_busy), 32'd0);
        check("reset done", 32'(bus.div_done), 32'd0);
        check("reset result", bus.div_result, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op("div_w 100/7", OP_DIV_W, 32'd100, 32'd7, -1);
        run_op("mod_w -7/2", OP_MOD_W, 32'hFFFF_FFF9, 32'd2, 0);
        run_op("div_w -7/2", OP_DIV_W, 32'hFFFF_FFF9, 32'd2, 0);
        run_op("div_wu ffffffff/2", OP_DIV_WU, 32'hFFFF_FFFF, 32'd2, 0);
        run_op("mod_wu ffffffff/2", OP_MOD_WU, 32'hFFFF_FFFF, 32'd2, 0);
        run_op("div_w 5/0", OP_DIV_W, 32'd5, 32'd0, 0);
        run_op("mod_wu 5/0", OP_MOD_WU, 32'd5, 32'd0, 0);
        run_op("div_w ovf", OP_DIV_W, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("mod_w ovf", OP_MOD_W, 32'h8000_0000, 32'hFFFF_FFFF, 0);

        // Flush in CALC cycle 10, then a fresh accept at cycle 12.
        @(negedge clk);
        bus.div_req = 1'b1; bus.div_op = OP_DIV_W;
        bus.div_src1 = 32'd100; bus.div_src2 = 32'd7;
        @(posedge clk);
        repeat (9) @(posedge clk);
        @(negedge clk);
        bus.div_flush = 1'b1;
        @(posedge clk); #1;
        check("flush busy", 32'(bus.div_busy), 32'd0);
        check("flush done", 32'(bus.div_done), 32'd0);
        @(negedge clk);
        bus.div_flush = 1'b0;
        bus.div_req   = 1'b0;
        run_op("div_w 9/3 after flush", OP_DIV_W, 32'd9, 32'd3, 0);

        // Flush wins over a pending result in DONE.
        @(negedge clk);
        bus.div_req = 1'b1; bus.div_op = OP_DIV_W;
        bus.div_src1 = 32'd5; bus.div_src2 = 32'd0;
        @(posedge clk); #1;
        check("pre-flush done", 32'(bus.div_done), 32'd1);
        @(negedge clk);
        bus.div_req = 1'b0; bus.div_flush = 1'b1;
        @(posedge clk); #1;
        check("flush in done", 32'(bus.div_done), 32'd0);
        @(negedge clk);
        bus.div_flush = 1'b0;

        run_op("div_wu 1000/10 backpressure", OP_DIV_WU, 32'd1000, 32'd10, 5);

        // Asynchronous reset in CALC cycle 20.
        @(negedge clk);
        bus.div_req = 1'b1; bus.div_op = OP_DIV_W;
        bus.div_src1 = 32'd100; bus.div_src2 = 32'd7;
        @(posedge clk);
        repeat (19) @(posedge clk);
        @(negedge clk);
        bus.div_req = 1'b0;
        reset = 1'b1;
        #1;
        check("async reset busy", 32'(bus.div_busy), 32'd0);
        check("async reset done", 32'(bus.div_done), 32'd0);
        check("async reset result", bus.div_result, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.div_done || bus.div_busy) seen++;
        end
        check("no activity after reset", 32'(seen), 32'd0);

        for (int n = 0; n < 24; n++) begin
            rop = 4'b0001 << $urandom_range(0, 3);
            ra  = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 15));
                2: rb = 32'hFFFF_FFFF;
                3: begin ra = 32'h8000_0000; rb = $urandom; end
                4: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                default: rb = $urandom;
            endcase
            run_op("random", rop, ra, rb, $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Iterative divider with its sequencing controller for the EXE stage; executes div.w, mod.w, div.wu and mod.wu.
- The EXE stage presents a request and holds it while the stage is stalled.
- The block runs a radix-2 restoring division, one quotient bit per cycle, and holds the result until the downstream stage accepts it.
- EXE uses div_done as its ready_go for divide-class instructions.

Parameters:
WIDTH, 32, operand/result width; iteration count equals WIDTH

Ports:
clk  input  1  clock, all state updates on posedge
reset  input  1  asynchronous, active-high reset
div_req  input  1  EXE valid and instruction is divide-class; held high while EXE stalls
div_op  input  4  one-hot {mod_wu, div_wu, mod_w, div_w}; sampled only on accept
div_src1  input  WIDTH  dividend (rj value); sampled only on accept
div_src2  input  WIDTH  divisor (rk value); sampled only on accept
div_flush  input  1  cancel in-flight operation (exception/branch flush of EXE)
div_ack  input  1  downstream accepts result (EXE ready_go && ms_allowin)
div_busy  output  1  state != IDLE
div_done  output  1  result valid; high for every cycle in DONE
div_result  output  WIDTH  quotient or remainder per latched op; valid while div_done

Behaviour:
- Reset, asynchronous, active-high. Clears the following:
  - state to IDLE
  - count to 0
  - partial remainder, quotient and latched operands to 0
  - outputs: div_busy=0, div_done=0, div_result=0
- State machine: IDLE, CALC, DONE.
- Accept: in IDLE with div_req=1 and div_flush=0. On accept, latch:
  - op
  - is_signed = div_w|mod_w
  - sign_q = is_signed & (src1[31]^src2[31])
  - sign_r = is_signed & src1[31]
  - |src1| and |src2| (two's-complement negation when signed and negative; 0x80000000 stays 0x80000000 and is treated as unsigned 2^31)
- Special cases, decided at accept. Next state is DONE directly, with CALC skipped (result visible 1 cycle after accept):
  - divisor==0: quotient=all ones, remainder=src1 unchanged.
  - Signed overflow (div_w/mod_w, src1=0x80000000, src2=0xFFFFFFFF): quotient=0x80000000, remainder=0.
- Normal accept: next state is CALC, count=0, partial remainder R=0, Q=|src1|.
- CALC, each cycle:
  - Shift {R,Q} left by 1.
  - Compute trial T = R_shifted - divisor, WIDTH+1 bits.
  - If T non-negative: R=T[WIDTH-1:0] and Q[0]=1; else keep R and Q[0]=0.
  - count++; when count reaches WIDTH-1 in a CALC cycle, next state is DONE.
  - CALC lasts exactly WIDTH cycles. For WIDTH=32, the accept is at cycle 0 and div_done rises at cycle 33.
- DONE: final fix-up is registered on entry, not combinational from the adder:
  - quotient = sign_q ? -Q : Q
  - remainder = sign_r ? -R : R
  - div_result = quotient for div_w/div_wu, remainder for mod_w/mod_wu.
  - div_result is held stable until the state leaves DONE.
- DONE with div_ack=1: next state IDLE, div_done falls the following cycle. div_req is ignored in DONE and CALC; a new operation is accepted only from IDLE, so there are no back-to-back accepts.
- DONE with div_ack=0: remain in DONE indefinitely, result held.
- div_flush=1 in any state: next state IDLE, and no div_done is produced for the cancelled op.
  - Flush has priority over accept and over div_ack.
  - Flush in the same cycle as DONE+ack still returns to IDLE (same next state).
- div_op with no bit or multiple bits set is not a legal accept; the block treats it as div_wu. This is out of contract for verification.
- Remainder sign follows the dividend, quotient truncates toward zero (LoongArch semantics).
- Reset mid-CALC: immediate IDLE, all registers cleared asynchronously; no done pulse after release.

Test Plan:
- Normal divide: div_w 100/7, ack held high → div_busy high from cycle 1, div_done at cycle 33, div_result=14 (0x0000000E); idle at cycle 34.
- Signed modulo: mod_w -7/2 (0xFFFFFFF9, 0x00000002) → result 0xFFFFFFFF (-1). Also div_w -7/2 → 0xFFFFFFFD (-3).
- Unsigned divide: div_wu 0xFFFFFFFF/2 → 0x7FFFFFFF; mod_wu 0xFFFFFFFF/2 → 1; both at cycle 33.
- Special cases, each with div_done at cycle 1:
  - div_w 5/0 → 0xFFFFFFFF
  - mod_wu 5/0 → 5
  - div_w 0x80000000/0xFFFFFFFF → 0x80000000
  - mod_w same operands → 0
- Flush and reset mid-operation:
  - div_flush at cycle 10 of CALC → IDLE at cycle 11, no div_done. A new div_w 9/3 accepted at cycle 12 gives 3 at cycle 45.
  - reset asserted at cycle 20 → outputs 0 immediately.
- Backpressure: div_ack held 0 for 5 cycles after done → div_done and div_result (div_wu 1000/10 = 100) stable throughout. IDLE the cycle after ack=1; div_req held high during DONE causes no re-accept.
